// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator sequencer: FSM states, opcodes, skip codes, ALU modes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH_A,
        S_LOAD_IRA,
        S_FETCH_B,
        S_LOAD_IRB,
        S_DECODE,
        S_MEM_RD,
        S_MBR_LD,
        S_EXEC,
        S_MEM_WR,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'h7;
    localparam logic [3:0] OP_SKIP  = 4'h8;
    localparam logic [3:0] OP_JUMP  = 4'h9;
    localparam logic [3:0] OP_CLEAR = 4'hA;

    localparam logic [1:0] SKIP_NEG   = 2'b00;
    localparam logic [1:0] SKIP_ZERO  = 2'b01;
    localparam logic [1:0] SKIP_POS   = 2'b10;
    localparam logic [1:0] SKIP_NEVER = 2'b11;

    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;

    // Instruction classes: how the sequencer leaves DECODE.
    localparam logic [2:0] IC_NOP   = 3'd0;
    localparam logic [2:0] IC_MEMRD = 3'd1;
    localparam logic [2:0] IC_STORE = 3'd2;
    localparam logic [2:0] IC_HALT  = 3'd3;
    localparam logic [2:0] IC_SKIP  = 3'd4;
    localparam logic [2:0] IC_JUMP  = 3'd5;
    localparam logic [2:0] IC_CLEAR = 3'd6;

endpackage

// File: rtl/cpu_decoder.sv
// Opcode decoder: maps IRA[7:4] to an instruction class, load flag and ALU mode.
// Latency: combinational.
// Backpressure: none.
module cpu_decoder
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [2:0] iclass,
    output logic       is_load,
    output logic [3:0] alu_sel
);

    always_comb begin
        iclass  = IC_NOP;
        is_load = 1'b0;
        alu_sel = ALU_NONE;
        case (opcode)
            OP_LOAD: begin
                iclass  = IC_MEMRD;
                is_load = 1'b1;
            end
            OP_ADD: begin
                iclass  = IC_MEMRD;
                alu_sel = ALU_ADD;
            end
            OP_SUB: begin
                iclass  = IC_MEMRD;
                alu_sel = ALU_SUB;
            end
            OP_AND: begin
                iclass  = IC_MEMRD;
                alu_sel = ALU_AND;
            end
            OP_OR: begin
                iclass  = IC_MEMRD;
                alu_sel = ALU_OR;
            end
            OP_STORE: iclass = IC_STORE;
            OP_HALT:  iclass = IC_HALT;
            OP_SKIP:  iclass = IC_SKIP;
            OP_JUMP:  iclass = IC_JUMP;
            OP_CLEAR: iclass = IC_CLEAR;
            default:  iclass = IC_NOP;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Two-byte-instruction accumulator sequencer driving a single-port synchronous RAM and an external ALU.
// Latency: 8 cycles for LOAD/ALU ops, 6 for STORE, 5 for SKIP/JUMP/CLEAR/NOP, fetch to fetch.
// Backpressure: none; RAM read data is assumed valid the cycle after the address.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [3:0]            alu_sel,
    input  logic [DATA_WIDTH-1:0] alu_s,
    output logic                  halted,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] ac
);

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PC_TWO = ADDR_WIDTH'(2);

    state_t                state;
    logic [DATA_WIDTH-1:0] ira;
    logic [ADDR_WIDTH-1:0] irb;
    logic [DATA_WIDTH-1:0] mbr;

    logic [2:0]            iclass;
    logic                  is_load;
    logic [3:0]            dec_alu_sel;
    logic                  skip_take;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic                  unused_ira;

    assign unused_ira = ^ira[3:2];

    cpu_decoder u_decoder (
        .opcode  (ira[7:4]),
        .iclass  (iclass),
        .is_load (is_load),
        .alu_sel (dec_alu_sel)
    );

    // Next PC for instructions that resolve in DECODE; PC already points past the operand byte.
    always_comb begin
        skip_take = 1'b0;
        case (ira[1:0])
            SKIP_NEG:  skip_take = ac[DATA_WIDTH-1];
            SKIP_ZERO: skip_take = (ac == '0);
            SKIP_POS:  skip_take = !ac[DATA_WIDTH-1] && (ac != '0);
            default:   skip_take = 1'b0;
        endcase
        pc_next = pc;
        if (iclass == IC_SKIP && skip_take) begin
            pc_next = pc + PC_TWO;
        end else if (iclass == IC_JUMP) begin
            pc_next = irb;
        end
    end

    // Outputs are registered: each transition loads the bus values for the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= '0;
            ira       <= '0;
            irb       <= '0;
            mbr       <= '0;
            ac        <= '0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_oe    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= ALU_NONE;
            halted    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FETCH_A;
                        pc       <= '0;
                        mem_addr <= '0;
                        mem_cs   <= 1'b1;
                        mem_oe   <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_FETCH_A: state <= S_LOAD_IRA;
                S_LOAD_IRA: begin
                    ira      <= mem_rdata;
                    pc       <= pc + PC_ONE;
                    mem_addr <= pc + PC_ONE;
                    state    <= S_FETCH_B;
                end
                S_FETCH_B: state <= S_LOAD_IRB;
                S_LOAD_IRB: begin
                    irb    <= ADDR_WIDTH'(mem_rdata);
                    pc     <= pc + PC_ONE;
                    mem_cs <= 1'b0;
                    mem_oe <= 1'b0;
                    state  <= S_DECODE;
                end
                S_DECODE: begin
                    case (iclass)
                        IC_MEMRD: begin
                            mem_addr <= irb;
                            mem_cs   <= 1'b1;
                            mem_oe   <= 1'b1;
                            state    <= S_MEM_RD;
                        end
                        IC_STORE: begin
                            mem_addr  <= irb;
                            mem_wdata <= ac;
                            mem_cs    <= 1'b1;
                            mem_we    <= 1'b1;
                            state     <= S_MEM_WR;
                        end
                        IC_HALT: begin
                            halted <= 1'b1;
                            busy   <= 1'b0;
                            state  <= S_HALT;
                        end
                        default: begin
                            if (iclass == IC_CLEAR) begin
                                ac <= '0;
                            end
                            pc       <= pc_next;
                            mem_addr <= pc_next;
                            mem_cs   <= 1'b1;
                            mem_oe   <= 1'b1;
                            state    <= S_FETCH_A;
                        end
                    endcase
                end
                S_MEM_RD: state <= S_MBR_LD;
                S_MBR_LD: begin
                    mbr     <= mem_rdata;
                    mem_cs  <= 1'b0;
                    mem_oe  <= 1'b0;
                    alu_sel <= dec_alu_sel;
                    if (!is_load) begin
                        alu_a <= ac;
                        alu_b <= mem_rdata;
                    end
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    ac       <= is_load ? mbr : alu_s;
                    alu_a    <= '0;
                    alu_b    <= '0;
                    alu_sel  <= ALU_NONE;
                    mem_addr <= pc;
                    mem_cs   <= 1'b1;
                    mem_oe   <= 1'b1;
                    state    <= S_FETCH_A;
                end
                S_MEM_WR: begin
                    mem_we   <= 1'b0;
                    mem_oe   <= 1'b1;
                    mem_addr <= pc;
                    state    <= S_FETCH_A;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: RAM and ALU models plus an instruction-level reference machine.
// Latency: n/a.
// Backpressure: n/a.
module tb_cpu_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       mem_cs, mem_we, mem_oe;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0] alu_a, alu_b, alu_s;
    logic [3:0] alu_sel;
    logic       halted, busy;
    logic [7:0] pc, ac;

    cpu_sequencer #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_oe    (mem_oe),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_s     (alu_s),
        .halted    (halted),
        .busy      (busy),
        .pc        (pc),
        .ac        (ac)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (alu_sel)
            4'b0011: alu_s = alu_a + alu_b;
            4'b0100: alu_s = alu_a - alu_b;
            4'b0101: alu_s = alu_a & alu_b;
            4'b0110: alu_s = alu_a | alu_b;
            default: alu_s = 8'h00;
        endcase
    end

    // RAM plus access logs; a read is logged each time a new address is presented with oe.
    logic [7:0]  img [256];
    logic [7:0]  ram [256];
    logic        load_en;
    logic        prev_oe;
    logic [7:0]  prev_addr;
    logic [7:0]  rd_log [$];
    logic [15:0] wr_log [$];

    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 256; i++) ram[i] <= img[i];
            rd_log.delete();
            wr_log.delete();
            prev_oe = 1'b0;
        end else begin
            if (mem_cs && mem_we) begin
                ram[mem_addr] <= mem_wdata;
                wr_log.push_back({mem_addr, mem_wdata});
            end
            if (mem_cs && mem_oe) begin
                mem_rdata <= ram[mem_addr];
                if (!prev_oe || mem_addr != prev_addr) rd_log.push_back(mem_addr);
            end
            prev_oe   = mem_cs && mem_oe;
            prev_addr = mem_addr;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference machine: executes whole instructions on its own memory copy.
    logic [7:0]  exp_rd [$];
    logic [15:0] exp_wr [$];
    logic [7:0]  m_pc, m_ac;
    bit          m_halt;

    task automatic model(input int k, output int cyc);
        logic [7:0] mm [256];
        logic [7:0] p, a, ia, ib;
        bit take;
        for (int i = 0; i < 256; i++) mm[i] = img[i];
        p = 8'h00; a = 8'h00; cyc = 0; m_halt = 0;
        exp_rd.delete();
        exp_wr.delete();
        for (int n = 0; n < k && !m_halt; n++) begin
            ia = mm[p]; exp_rd.push_back(p); p = p + 8'd1;
            ib = mm[p]; exp_rd.push_back(p); p = p + 8'd1;
            cyc += 5;
            case (ia[7:4])
                4'h1, 4'h3, 4'h4, 4'h5, 4'h6: begin
                    exp_rd.push_back(ib);
                    cyc += 3;
                    case (ia[7:4])
                        4'h1:    a = mm[ib];
                        4'h3:    a = a + mm[ib];
                        4'h4:    a = a - mm[ib];
                        4'h5:    a = a & mm[ib];
                        default: a = a | mm[ib];
                    endcase
                end
                4'h2: begin
                    mm[ib] = a;
                    exp_wr.push_back({ib, a});
                    cyc += 1;
                end
                4'h7: m_halt = 1;
                4'h8: begin
                    case (ia[1:0])
                        2'b00:   take = ($signed(a) < 0);
                        2'b01:   take = (a == 8'h00);
                        2'b10:   take = ($signed(a) > 0);
                        default: take = 0;
                    endcase
                    if (take) p = p + 8'd2;
                end
                4'h9: p = ib;
                4'hA: a = 8'h00;
                default: ;
            endcase
        end
        m_pc = p;
        m_ac = a;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
    endtask

    task automatic do_reset();
        start = 1'b0;
        rst = 1'b1;
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs k instructions from reset and compares state, timing and bus traffic with the model.
    task automatic run_prog(input string tag, input int k);
        int cyc;
        model(k, cyc);
        do_reset();
        pulse_start();
        chk({tag, "_busy_start"}, busy, 1);
        repeat (cyc - 1) @(negedge clk);
        chk({tag, "_halted_early"}, halted, 0);
        @(negedge clk);
        chk({tag, "_pc"}, pc, m_pc);
        chk({tag, "_ac"}, ac, m_ac);
        chk({tag, "_halted"}, halted, m_halt);
        chk({tag, "_busy"}, busy, !m_halt);
        chk({tag, "_rd_cnt"}, rd_log.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
            chk({tag, "_rd_addr"}, rd_log[i], exp_rd[i]);
        chk({tag, "_wr_cnt"}, wr_log.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
            chk({tag, "_wr"}, wr_log[i], exp_wr[i]);
        if (m_halt) begin
            repeat (4) @(negedge clk);
            chk({tag, "_frozen_pc"}, pc, m_pc);
            chk({tag, "_frozen_ac"}, ac, m_ac);
            chk({tag, "_frozen_cs"}, mem_cs, 0);
            chk({tag, "_frozen_rd"}, rd_log.size(), exp_rd.size());
        end
    endtask

    initial begin
        int t;
        rst = 1'b1;
        start = 1'b0;
        load_en = 1'b0;
        clear_img();
        @(negedge clk);
        chk("rst_cs", mem_cs, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_oe", mem_oe, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_alu", {alu_a, alu_b, alu_sel}, 0);
        chk("rst_flags", {halted, busy}, 0);
        chk("rst_pc", pc, 0);
        chk("rst_ac", ac, 0);

        // LOAD [06], ADD [07], HALT
        clear_img();
        img[0] = 8'h10; img[1] = 8'h06; img[2] = 8'h30; img[3] = 8'h07; img[4] = 8'h70;
        img[6] = 8'h05; img[7] = 8'h03;
        run_prog("prog", 3);
        chk("prog_ac_const", ac, 8'h08);
        chk("prog_pc_const", pc, 8'h06);

        // LOAD 0x2A, STORE to 0x40, HALT
        clear_img();
        img[0] = 8'h10; img[1] = 8'h50; img[2] = 8'h20; img[3] = 8'h40; img[4] = 8'h70;
        img[8'h50] = 8'h2A;
        run_prog("store", 3);
        chk("store_pulse", wr_log.size(), 1);
        chk("store_bus", wr_log[0], 16'h402A);
        chk("store_ram", ram[8'h40], 8'h2A);

        // SKIP-if-zero at 0x16 with AC=0: taken
        clear_img();
        img[0] = 8'h90; img[1] = 8'h16; img[8'h16] = 8'h81; img[8'h1A] = 8'h70;
        run_prog("skz_take", 3);
        chk("skz_take_fetch", rd_log[4], 8'h1A);

        // SKIP-if-zero at 0x16 with AC=1: not taken
        clear_img();
        img[0] = 8'h10; img[1] = 8'hF0; img[8'hF0] = 8'h01;
        img[2] = 8'h90; img[3] = 8'h16; img[8'h16] = 8'h81; img[8'h18] = 8'h70;
        run_prog("skz_not", 4);
        chk("skz_not_fetch", rd_log[7], 8'h18);

        // AC=0xFF: skip-if-negative taken, skip-if-positive not taken
        clear_img();
        img[0] = 8'h10; img[1] = 8'hF0; img[8'hF0] = 8'hFF;
        img[2] = 8'h80; img[6] = 8'h82; img[8] = 8'h70;
        run_prog("skneg", 4);
        chk("skneg_fetch", rd_log[5], 8'h06);
        chk("skpos_fetch", rd_log[7], 8'h08);
        chk("skneg_pc", pc, 8'h0A);

        // JUMP 0xFE onto a NOP: PC wraps to 0x00
        clear_img();
        img[0] = 8'h90; img[1] = 8'hFE;
        run_prog("wrap", 2);
        chk("wrap_pc", pc, 8'h00);
        chk("wrap_fetch", rd_log[2], 8'hFE);

        // Reset during MEM_WR
        clear_img();
        img[0] = 8'h10; img[1] = 8'h50; img[2] = 8'h20; img[3] = 8'h40; img[4] = 8'h70;
        img[8'h50] = 8'h2A;
        do_reset();
        pulse_start();
        t = 0;
        while (!mem_we && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("abort_wr_seen", mem_we, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_wr_we", mem_we, 0);
        chk("abort_wr_cs", mem_cs, 0);
        chk("abort_wr_bus", {mem_addr, mem_wdata}, 0);
        chk("abort_wr_regs", {pc, ac}, 0);
        chk("abort_wr_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_wr_ram", ram[8'h40], 8'h00);
        pulse_start();
        chk("restart_addr", mem_addr, 8'h00);
        chk("restart_oe", mem_oe, 1);

        // Reset during MBR_LD of the refetched LOAD
        repeat (6) @(negedge clk);
        chk("abort_mbr_oe_before", {mem_oe, mem_addr}, {1'b1, 8'h50});
        #2 rst = 1'b1;
        #1;
        chk("abort_mbr_oe", mem_oe, 0);
        chk("abort_mbr_addr", mem_addr, 0);
        chk("abort_mbr_regs", {pc, ac}, 0);
        chk("abort_mbr_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        chk("restart2_addr", mem_addr, 8'h00);
        chk("restart2_busy", busy, 1);

        // Random programs over a fully random memory image
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
            run_prog("rand", int'($urandom_range(1, 30)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
